// File: rtl/sliding_window_former_pkg.sv
// Shared definitions for the sliding window former, its line buffer and window consumers.
package sliding_window_former_pkg;

    // Flat bit index of the window cell r lines above and c columns left of the newest pixel.
    function automatic int unsigned idx(input int unsigned r, input int unsigned c,
                                        input int unsigned n);
        return r * n + c;
    endfunction

    // True when the counter widths can address every column and row of the image.
    function automatic bit counter_widths_ok(input int unsigned addr_width,
                                             input int unsigned image_width,
                                             input int unsigned row_width,
                                             input int unsigned image_height);
        return (image_width <= (32'd1 << addr_width)) && (image_height <= (32'd1 << row_width));
    endfunction

endpackage

// File: rtl/sliding_window_former_if.sv
// Pixel stream in, line buffer port, and window output of the sliding window former.
interface sliding_window_former_if #(
    parameter int unsigned AddrWidth  = 3,
    parameter int unsigned RowWidth   = 3,
    parameter int unsigned WindowSize = 3
);
    logic                               pixel_valid;
    logic                               pixel;
    logic                               lb_write_enable_c;
    logic [AddrWidth-1:0]               lb_addr_c;
    logic                               lb_data_c;
    logic [WindowSize-2:0]              lb_line_data;
    logic [WindowSize*WindowSize-1:0]   window;
    logic                               window_valid;
    logic [RowWidth-1:0]                window_row;
    logic [AddrWidth-1:0]               window_col;
    logic                               frame_done;

    modport master (
        input  pixel_valid, pixel, lb_line_data,
        output lb_write_enable_c, lb_addr_c, lb_data_c,
        output window, window_valid, window_row, window_col, frame_done
    );

    modport slave (
        output pixel_valid, pixel, lb_line_data,
        input  lb_write_enable_c, lb_addr_c, lb_data_c,
        input  window, window_valid, window_row, window_col, frame_done
    );
endinterface

// File: rtl/sliding_window_former_raster_counter.sv
// Column/row position of the next pixel in raster order, advancing once per accepted pixel.
module sliding_window_former_raster_counter #(
    parameter int unsigned AddrWidth   = 3,
    parameter int unsigned RowWidth    = 3,
    parameter int unsigned ImageWidth  = 7,
    parameter int unsigned ImageHeight = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 advance,
    output logic [AddrWidth-1:0] col_q,
    output logic [RowWidth-1:0]  row_q,
    output logic                 frame_end_c
);
    logic [AddrWidth-1:0] col_d;
    logic [RowWidth-1:0]  row_d;
    logic                 line_end_c;

    assign line_end_c  = advance && (col_q == AddrWidth'(ImageWidth - 1));
    assign frame_end_c = line_end_c && (row_q == RowWidth'(ImageHeight - 1));

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (line_end_c) begin
            col_d = '0;
            row_d = frame_end_c ? '0 : row_q + RowWidth'(1);
        end else if (advance) begin
            col_d = col_q + AddrWidth'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end
endmodule

// File: rtl/sliding_window_former.sv
// Forms n x n binary neighbourhoods from a raster pixel stream plus the line buffer's buffered column.
module sliding_window_former
    import sliding_window_former_pkg::*;
#(
    parameter int unsigned AddrWidth   = 3,
    parameter int unsigned ImageWidth  = 7,
    parameter int unsigned ImageHeight = 7,
    parameter int unsigned RowWidth    = 3,
    parameter int unsigned WindowSize  = 3
) (
    input logic                     clk,
    input logic                     rst,
    sliding_window_former_if.master bus
);
    localparam int unsigned WinBits = WindowSize * WindowSize;
    localparam int unsigned IdxW    = $clog2(WinBits);
    localparam int unsigned VecW    = $clog2(WindowSize);

    if (!counter_widths_ok(AddrWidth, ImageWidth, RowWidth, ImageHeight) || WindowSize < 2) begin : g_bad_cfg
        $error("sliding_window_former: counter widths too narrow or WindowSize < 2");
    end

    logic [AddrWidth-1:0]  col_q;
    logic [RowWidth-1:0]   row_q;
    logic                  frame_end_c;
    logic [WindowSize-1:0] col_vec_c;

    logic [WinBits-1:0]    window_q, window_d;
    logic                  window_valid_q, window_valid_d;
    logic [RowWidth-1:0]   window_row_q, window_row_d;
    logic [AddrWidth-1:0]  window_col_q, window_col_d;
    logic                  frame_done_q, frame_done_d;

    sliding_window_former_raster_counter #(
        .AddrWidth  (AddrWidth),
        .RowWidth   (RowWidth),
        .ImageWidth (ImageWidth),
        .ImageHeight(ImageHeight)
    ) u_raster_counter (
        .clk        (clk),
        .rst        (rst),
        .advance    (bus.pixel_valid),
        .col_q      (col_q),
        .row_q      (row_q),
        .frame_end_c(frame_end_c)
    );

    assign bus.lb_addr_c         = col_q;
    assign bus.lb_write_enable_c = bus.pixel_valid;
    assign bus.lb_data_c         = bus.pixel;

    // Newest column: bit 0 is the incoming pixel, bit k the pixel k lines above it.
    assign col_vec_c = {bus.lb_line_data, bus.pixel};

    always_comb begin
        window_d       = window_q;
        window_valid_d = 1'b0;
        window_row_d   = window_row_q;
        window_col_d   = window_col_q;
        frame_done_d   = 1'b0;
        if (bus.pixel_valid) begin
            for (int unsigned r = 0; r < WindowSize; r++) begin
                window_d[IdxW'(idx(r, 0, WindowSize))] = col_vec_c[VecW'(r)];
                for (int unsigned c = 1; c < WindowSize; c++) begin
                    window_d[IdxW'(idx(r, c, WindowSize))] = window_q[IdxW'(idx(r, c - 1, WindowSize))];
                end
            end
            window_valid_d = (row_q >= RowWidth'(WindowSize - 1)) &&
                             (col_q >= AddrWidth'(WindowSize - 1));
            window_row_d   = row_q;
            window_col_d   = col_q;
            frame_done_d   = frame_end_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            window_q       <= '0;
            window_valid_q <= 1'b0;
            window_row_q   <= '0;
            window_col_q   <= '0;
            frame_done_q   <= 1'b0;
        end else begin
            window_q       <= window_d;
            window_valid_q <= window_valid_d;
            window_row_q   <= window_row_d;
            window_col_q   <= window_col_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign bus.window       = window_q;
    assign bus.window_valid = window_valid_q;
    assign bus.window_row   = window_row_q;
    assign bus.window_col   = window_col_q;
    assign bus.frame_done   = frame_done_q;
endmodule

// File: tb/tb_sliding_window_former.sv
// Bench for sliding_window_former: behavioural line buffer, frame-image reference model, vector table.
module tb_sliding_window_former;
    localparam int AW = 3;
    localparam int RW = 3;
    localparam int IW = 7;
    localparam int IH = 7;
    localparam int N  = 3;
    localparam int LBW = N - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sliding_window_former_if #(.AddrWidth(AW), .RowWidth(RW), .WindowSize(N)) bus ();

    sliding_window_former #(
        .AddrWidth(AW), .ImageWidth(IW), .ImageHeight(IH), .RowWidth(RW), .WindowSize(N)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Line buffer: returns pre-write column, shifts the new pixel in at the edge.
    logic [LBW-1:0] lb_mem [0:(1<<AW)-1];
    assign bus.lb_line_data = lb_mem[bus.lb_addr_c];
    always @(posedge clk)
        if (bus.lb_write_enable_c)
            lb_mem[bus.lb_addr_c] <= LBW'({lb_mem[bus.lb_addr_c], bus.lb_data_c});

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the frame as a 2D image plus the raster position of the next pixel.
    bit       img [IH][IW];
    int       m_row, m_col;
    bit       e_valid, e_fd;
    bit [8:0] e_win;
    int       e_row, e_col;

    int       n_valid_seen, n_fd_seen;
    logic [8:0] win_at [IH][IW];

    typedef struct {
        bit v; bit p; int addr; int row; int col; bit valid;
    } vec_t;
    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_accept(input bit v, input bit p);
        int pos;
        if (!v) begin
            e_valid = 1'b0;
            e_fd    = 1'b0;
            return;
        end
        img[m_row][m_col] = p;
        e_valid = (m_row >= N - 1) && (m_col >= N - 1);
        e_win   = '0;
        if (e_valid)
            for (int dr = 0; dr < N; dr++)
                for (int dc = 0; dc < N; dc++)
                    e_win[dr*N+dc] = img[m_row-dr][m_col-dc];
        e_row = m_row;
        e_col = m_col;
        e_fd  = (m_row == IH - 1) && (m_col == IW - 1);
        pos = m_row * IW + m_col + 1;
        if (pos == IW * IH) pos = 0;
        m_row = pos / IW;
        m_col = pos % IW;
    endfunction

    task automatic step(input bit v, input bit p);
        bus.pixel_valid = v;
        bus.pixel       = p;
        #1;
        chk("lb_addr", 32'(bus.lb_addr_c), m_col);
        chk("lb_we", 32'(bus.lb_write_enable_c), 32'(v));
        chk("lb_data", 32'(bus.lb_data_c), 32'(p));
        model_accept(v, p);
        @(posedge clk);
        #1;
        chk("window_valid", 32'(bus.window_valid), 32'(e_valid));
        chk("frame_done", 32'(bus.frame_done), 32'(e_fd));
        chk("window_row", 32'(bus.window_row), e_row);
        chk("window_col", 32'(bus.window_col), e_col);
        if (e_valid) chk("window", 32'(bus.window), 32'(e_win));
        if (bus.window_valid === 1'b1) begin
            n_valid_seen++;
            win_at[bus.window_row][bus.window_col] = bus.window;
        end
        if (bus.frame_done === 1'b1) n_fd_seen++;
    endtask

    task automatic do_reset(input bit v);
        rst = 1'b1;
        bus.pixel_valid = v;
        bus.pixel       = 1'b1;
        #1;
        chk("lb_we_during_reset", 32'(bus.lb_write_enable_c), 32'(v));
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.pixel_valid = 1'b0;
        m_row = 0; m_col = 0; e_valid = 0; e_fd = 0; e_row = 0; e_col = 0;
        #1;
        chk("rst_window", 32'(bus.window), 0);
        chk("rst_window_valid", 32'(bus.window_valid), 0);
        chk("rst_window_row", 32'(bus.window_row), 0);
        chk("rst_window_col", 32'(bus.window_col), 0);
        chk("rst_frame_done", 32'(bus.frame_done), 0);
        chk("rst_lb_addr", 32'(bus.lb_addr_c), 0);
    endtask

    task automatic clear_obs();
        n_valid_seen = 0;
        n_fd_seen    = 0;
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++)
                win_at[r][c] = '0;
    endtask

    initial begin
        int first_idx;
        int nz;
        bus.pixel_valid = 1'b0;
        bus.pixel       = 1'b0;
        for (int a = 0; a < (1 << AW); a++) lb_mem[a] = '0;
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++)
                img[r][c] = 1'b0;

        tbl[0]  = '{1'b1, 1'b1, 0, 0, 0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1, 0, 1, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 2, 0, 1, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 2, 0, 2, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 3, 0, 3, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 4, 0, 4, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 5, 0, 5, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 6, 0, 6, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 0, 0, 6, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 0, 1, 0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1, 1, 1, 1'b0};

        // Reset state and address wrap across a line boundary.
        do_reset(1'b0);
        for (int i = 0; i < 11; i++) begin
            chk("tbl_lb_addr", 32'(bus.lb_addr_c), tbl[i].addr);
            step(tbl[i].v, tbl[i].p);
            chk("tbl_window_row", 32'(bus.window_row), tbl[i].row);
            chk("tbl_window_col", 32'(bus.window_col), tbl[i].col);
            chk("tbl_window_valid", 32'(bus.window_valid), 32'(tbl[i].valid));
        end

        // Reset mid-frame (asserted together with a pixel), then an all-ones frame.
        do_reset(1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'($urandom_range(1, 0)));
        do_reset(1'b1);
        clear_obs();
        first_idx = -1;
        for (int i = 0; i < IW * IH; i++) begin
            step(1'b1, 1'b1);
            if (bus.window_valid === 1'b1 && first_idx < 0) first_idx = i;
        end
        chk("ones_first_valid_idx", first_idx, 16);
        chk("ones_valid_count", n_valid_seen, 25);
        chk("ones_frame_done_count", n_fd_seen, 1);
        chk("ones_window_2_2", 32'(win_at[2][2]), 32'h1FF);
        chk("ones_window_6_6", 32'(win_at[6][6]), 32'h1FF);

        // Single one at (3,3), contiguous.
        clear_obs();
        for (int i = 0; i < IW * IH; i++) step(1'b1, 1'(i == 3 * IW + 3));
        nz = 0;
        for (int r = N - 1; r < IH; r++)
            for (int c = N - 1; c < IW; c++)
                if (win_at[r][c] != '0) nz++;
        chk("single_nonzero_count", nz, 9);
        chk("single_window_4_4", 32'(win_at[4][4]), 32'h010);
        chk("single_window_5_5", 32'(win_at[5][5]), 32'h100);
        chk("single_window_3_3", 32'(win_at[3][3]), 32'h001);
        chk("single_window_6_6", 32'(win_at[6][6]), 32'h000);

        // Same frame with PixelValid toggling every other cycle.
        clear_obs();
        for (int i = 0; i < IW * IH; i++) begin
            step(1'b1, 1'(i == 3 * IW + 3));
            step(1'b0, 1'($urandom_range(1, 0)));
        end
        chk("gap_valid_count", n_valid_seen, 25);
        chk("gap_window_4_4", 32'(win_at[4][4]), 32'h010);
        chk("gap_frame_done_count", n_fd_seen, 1);

        // Two back-to-back random frames.
        clear_obs();
        for (int i = 0; i < 2 * IW * IH; i++) step(1'b1, 1'($urandom_range(1, 0)));
        chk("b2b_valid_count", n_valid_seen, 50);
        chk("b2b_frame_done_count", n_fd_seen, 2);

        // Random valid/pixel stream against the model.
        for (int i = 0; i < 400; i++) step(1'($urandom_range(3, 0) != 0), 1'($urandom_range(1, 0)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sliding_window_former.md
# sliding_window_former

Streaming stage that pairs with the line buffer to turn a raster-ordered binary pixel stream into WindowSize x WindowSize neighbourhoods. It accepts one pixel per valid cycle and drives the line buffer's write port and column address. It combines the buffered column returned by the line buffer with the incoming pixel and shifts that column into a registered window. Window consumers (morphology and pattern-match stages) receive a window plus a valid pulse and coordinates.

## Interface
Parameters:
- AddrWidth, 3, width of column address; 2^AddrWidth >= ImageWidth
- ImageWidth, 7, pixels per line
- ImageHeight, 7, lines per frame
- RowWidth, 3, width of row counter; 2^RowWidth >= ImageHeight
- WindowSize, 3, window edge n (n >= 2, n <= ImageWidth, n <= ImageHeight)

Ports (one synchronous clock; reset is synchronous and active-high):
- Clock  in  1  sole clock, rising edge
- Reset  in  1  synchronous, active-high
- PixelValid  in  1  Pixel is valid this cycle
- Pixel  in  1  binary pixel, raster order
- LbWriteEnable  out  1  line buffer write enable
- LbAddr  out  AddrWidth  line buffer column address
- LbData  out  1  line buffer write data
- LbLineData  in  WindowSize-1  buffered column at LbAddr; bit k = pixel from k+1 lines above
- Window  out  WindowSize*WindowSize  window; bit r*n+c = pixel r lines above and c columns left of newest pixel
- WindowValid  out  1  Window holds a complete in-image neighbourhood
- WindowRow  out  RowWidth  row of newest pixel in Window
- WindowCol  out  AddrWidth  column of newest pixel in Window
- FrameDone  out  1  one-cycle pulse after the last pixel of a frame

## Operation
- Column counter col (0..ImageWidth-1) and row counter row (0..ImageHeight-1) track the position of the next pixel.
- Combinational outputs to the line buffer:
  - LbAddr = col
  - LbWriteEnable = PixelValid
  - LbData = Pixel
- LbLineData is a combinational read of the pre-write contents at LbAddr. The write commits at the same edge.
- Accepted pixel (PixelValid=1 at an edge):
  - New column vector v: v[0] = Pixel; v[k] = LbLineData[k-1] for k = 1..n-1.
  - Window shifts one column: Window[r*n+c] <= Window[r*n+c-1] for c >= 1, and Window[r*n+0] <= v[r].
  - WindowValid <= (row >= n-1) && (col >= n-1).
  - WindowRow <= row; WindowCol <= col.
  - col increments; at ImageWidth-1 it wraps to 0 and row increments.
  - At row = ImageHeight-1 and col = ImageWidth-1, both counters go to 0 and FrameDone <= 1.
- No pixel (PixelValid=0): counters, Window, WindowRow and WindowCol hold. WindowValid <= 0 and FrameDone <= 0.
- Stale window columns from the previous line are fully shifted out before col reaches n-1, so no clearing is needed at line start.
- Line buffer contents are never cleared. Rows 0..n-2 of each frame never produce WindowValid, so stale data from the previous frame is never exposed.

## Timing
- Latency: one cycle. The window containing the pixel accepted at edge t is visible after edge t, with WindowValid high for exactly that cycle.
- Throughput: one pixel per cycle. No backpressure; the consumer must accept every WindowValid pulse.
- Reset values: col=0, row=0, Window=0, WindowValid=0, WindowRow=0, WindowCol=0, FrameDone=0.
- Reset asserted together with PixelValid: reset wins and the pixel is dropped. LbWriteEnable still follows PixelValid combinationally; that harmless write is overwritten in the next frame.
- Reset mid-frame aborts the frame. The next accepted pixel is treated as (0,0).
- Valid windows per frame: (ImageHeight-n+1)*(ImageWidth-n+1).

## Structure
- Shared package: window-index function idx(r,c)=r*n+c, and counter-width check constants (ImageWidth <= 2^AddrWidth, ImageHeight <= 2^RowWidth) used by line buffer, this block and consumers.
- One natural sub-module: raster_counter, holding col/row counters with advance input and wrap/frame-end outputs. The window shift register stays in the top.
- Top level instantiates this block next to the line buffer; their Addr/WriteEnable/Data/LineData ports connect one-to-one.

## Test plan
All cases use default parameters (7x7 image, n=3) and a behavioural line buffer model.
- Reset mid-frame: 10 pixels, pulse Reset, then 49 ones -> all outputs 0 after reset; LbAddr restarts at 0; first WindowValid follows the pixel at (2,2), Window=9'h1FF.
- All-ones frame, 49 consecutive pixels -> exactly 25 WindowValid pulses, first one after pixel index 16; Window=9'h1FF on each; FrameDone high one cycle after pixel 48.
- Single 1 at (3,3), rest 0 -> exactly 9 valid windows nonzero, those with newest at rows/cols 3..5. Newest (4,4) gives Window=9'h010 (bit 4); newest (5,5) gives bit 8.
- PixelValid toggling every other cycle, same frame -> identical Window/WindowRow/WindowCol sequence on valid pulses; LbWriteEnable=0 in gaps; counters hold.
- Two back-to-back frames -> no WindowValid during rows 0-1 of frame 2; frame 2 windows match frame 2 data only; FrameDone pulses twice.
- Address wrap -> LbAddr sequence 0,1,...,6,0,1 across a line boundary; WindowCol matches it on accepted pixels.
